// File: rtl/gr_pkg.sv
// Shared constants and address type for the general-register file.
package gr_pkg;
    localparam int REG_W = 32;
    localparam int NREG = 32;

    typedef logic [4:0] reg_addr_t;

    localparam reg_addr_t GR0_ADDR = 5'd0;
endpackage

// File: rtl/decoder5x32.sv
// 5-to-32 one-hot decoder with enable; all outputs low when E is low.
module DECODER5x32 (
    input  logic [4:0]  D,
    input  logic        E,
    output logic [31:0] O
);
    always_comb begin
        O = '0;
        if (E) O[D] = 1'b1;
    end
endmodule

// File: rtl/gr_file_2r1w.sv
// 32x32 general-register file: two bypassed combinational read ports, one write
// port, GR0 hardwired to zero, and a pending-write scoreboard for RAW detection.
module gr_file_2r1w
    import gr_pkg::*;
#(
    parameter int REG_W_P = REG_W,
    parameter int NREG_P  = NREG
) (
    input  logic                clk,
    input  logic                rst,
    input  reg_addr_t           ra_a,
    input  reg_addr_t           ra_b,
    output logic [REG_W_P-1:0]  rd_a,
    output logic [REG_W_P-1:0]  rd_b,
    input  logic                we,
    input  reg_addr_t           wa,
    input  logic [REG_W_P-1:0]  wd,
    input  logic                iss_en,
    input  reg_addr_t           iss_rd,
    output logic                busy_a,
    output logic                busy_b,
    output logic [NREG_P-1:0]   busy_vec
);
    logic [NREG_P-1:0][REG_W_P-1:0] regs;
    logic [NREG_P-1:0]              sb;
    logic [31:0]                    wdec;
    logic [31:0]                    idec;
    logic [NREG_P-1:0]              wen;
    logic [NREG_P-1:0]              sb_set;
    logic                           we_q;
    logic                           hit_a;
    logic                           hit_b;

    // Write and issue requests are suppressed while reset is held.
    assign we_q = we & ~rst;

    DECODER5x32 u_wdec (.D(wa),     .E(we_q),          .O(wdec));
    DECODER5x32 u_idec (.D(iss_rd), .E(iss_en & ~rst), .O(idec));

    // Bit 0 masked: GR0 is never written and never marked pending.
    assign wen    = wdec[NREG_P-1:0] & {{(NREG_P-1){1'b1}}, 1'b0};
    assign sb_set = idec[NREG_P-1:0] & {{(NREG_P-1){1'b1}}, 1'b0};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs <= '0;
        end else begin
            for (int i = 1; i < NREG_P; i++) begin
                if (wen[i]) regs[i] <= wd;
            end
        end
    end

    // Clear first, then set, so a newer issue to the same register wins.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) sb <= '0;
        else     sb <= (sb & ~wdec[NREG_P-1:0]) | sb_set;
    end

    assign hit_a = we_q && (wa == ra_a);
    assign hit_b = we_q && (wa == ra_b);

    always_comb begin
        rd_a = regs[ra_a];
        rd_b = regs[ra_b];
        if (hit_a)            rd_a = wd;
        if (hit_b)            rd_b = wd;
        if (ra_a == GR0_ADDR) rd_a = '0;
        if (ra_b == GR0_ADDR) rd_b = '0;
    end

    assign busy_a   = sb[ra_a] & ~hit_a;
    assign busy_b   = sb[ra_b] & ~hit_b;
    assign busy_vec = sb;
endmodule

// File: tb/tb_gr_file_2r1w.sv
// Directed vector table plus randomized traffic checked against an array model.
module tb_gr_file_2r1w;
    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  ra_a, ra_b, wa, iss_rd;
    logic [31:0] rd_a, rd_b, wd, busy_vec;
    logic        we, iss_en, busy_a, busy_b;

    int checks = 0;
    int errors = 0;

    // Behavioural model: plain register array and pending flags.
    logic [31:0] m_gr [32];
    bit          m_pend [32];

    typedef struct {
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        iss_en;
        logic [4:0]  iss_rd;
        logic [4:0]  ra_a;
        logic [4:0]  ra_b;
        logic [31:0] e_rd_a;
        logic [31:0] e_rd_b;
        logic        e_ba;
        logic        e_bb;
        logic [31:0] e_vec;
    } vec_t;

    vec_t tbl [16];

    gr_file_2r1w dut (
        .clk(clk), .rst(rst), .ra_a(ra_a), .ra_b(ra_b), .rd_a(rd_a), .rd_b(rd_b),
        .we(we), .wa(wa), .wd(wd), .iss_en(iss_en), .iss_rd(iss_rd),
        .busy_a(busy_a), .busy_b(busy_b), .busy_vec(busy_vec)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            m_gr[i] = '0;
            m_pend[i] = 1'b0;
        end
    endtask

    function automatic logic [31:0] m_rd(input logic [4:0] ra);
        if (ra == 0) return 32'h0;
        if (we && wa == ra) return wd;
        return m_gr[ra];
    endfunction

    function automatic logic m_busy(input logic [4:0] ra);
        if (ra == 0) return 1'b0;
        if (we && wa == ra) return 1'b0;
        return m_pend[ra];
    endfunction

    function automatic logic [31:0] m_vec();
        logic [31:0] v = '0;
        for (int i = 0; i < 32; i++) if (m_pend[i]) v[i] = 1'b1;
        return v;
    endfunction

    // Architectural effect of one clock edge on the model.
    task automatic model_edge();
        if (rst) return;
        if (we && wa != 0) m_gr[wa] = wd;
        if (we) m_pend[wa] = 1'b0;
        if (iss_en && iss_rd != 0) m_pend[iss_rd] = 1'b1;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle();
        we = 0; wa = 0; wd = 0; iss_en = 0; iss_rd = 0;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        ra_a = 0; ra_b = 0;
        model_reset();

        // Reset: outputs are zero across addresses while rst is held.
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            for (int r = 0; r < 32; r += 5) begin
                ra_a = 5'(r); ra_b = 5'(31 - r);
                #0.5;
                chk("reset_rd_a", rd_a, 32'h0);
                chk("reset_rd_b", rd_b, 32'h0);
            end
            chk("reset_vec", busy_vec, 32'h0);
        end
        rst = 1'b0;
        ra_a = 5'd7;
        #2;
        chk("post_reset_rd7", rd_a, 32'h0);

        //          we wa  wd            iss rd  ra_a ra_b  e_rd_a        e_rd_b        ba bb vec
        tbl[0]  = '{1, 5,  32'hDEADBEEF, 0,  0,  5,   0,    32'hDEADBEEF, 32'h0,        0, 0, 32'h0};
        tbl[1]  = '{0, 0,  32'h0,        0,  0,  5,   5,    32'hDEADBEEF, 32'hDEADBEEF, 0, 0, 32'h0};
        tbl[2]  = '{1, 9,  32'h1234,     0,  0,  9,   5,    32'h1234,     32'hDEADBEEF, 0, 0, 32'h0};
        tbl[3]  = '{1, 0,  32'hFFFFFFFF, 0,  0,  0,   9,    32'h0,        32'h1234,     0, 0, 32'h0};
        tbl[4]  = '{0, 0,  32'h0,        0,  0,  0,   0,    32'h0,        32'h0,        0, 0, 32'h0};
        tbl[5]  = '{0, 0,  32'h0,        1,  3,  3,   0,    32'h0,        32'h0,        0, 0, 32'h0};
        tbl[6]  = '{0, 0,  32'h0,        0,  0,  3,   3,    32'h0,        32'h0,        1, 1, 32'h8};
        tbl[7]  = '{1, 3,  32'h33,       0,  0,  3,   3,    32'h33,       32'h33,       0, 0, 32'h8};
        tbl[8]  = '{0, 0,  32'h0,        0,  0,  3,   0,    32'h33,       32'h0,        0, 0, 32'h0};
        tbl[9]  = '{1, 4,  32'h44,       1,  4,  4,   0,    32'h44,       32'h0,        0, 0, 32'h0};
        tbl[10] = '{0, 0,  32'h0,        0,  0,  4,   0,    32'h44,       32'h0,        1, 0, 32'h10};
        tbl[11] = '{0, 0,  32'h0,        1,  2,  0,   0,    32'h0,        32'h0,        0, 0, 32'h10};
        tbl[12] = '{1, 2,  32'h22,       1,  6,  2,   6,    32'h22,       32'h0,        0, 0, 32'h14};
        tbl[13] = '{0, 0,  32'h0,        0,  0,  2,   6,    32'h22,       32'h0,        0, 1, 32'h50};
        tbl[14] = '{0, 0,  32'h0,        1,  0,  0,   0,    32'h0,        32'h0,        0, 0, 32'h50};
        tbl[15] = '{0, 0,  32'h0,        0,  0,  0,   4,    32'h0,        32'h44,       0, 1, 32'h50};

        @(negedge clk);
        for (int i = 0; i < 16; i++) begin
            we = tbl[i].we; wa = tbl[i].wa; wd = tbl[i].wd;
            iss_en = tbl[i].iss_en; iss_rd = tbl[i].iss_rd;
            ra_a = tbl[i].ra_a; ra_b = tbl[i].ra_b;
            #2;
            chk($sformatf("tbl%0d_rd_a", i), rd_a, tbl[i].e_rd_a);
            chk($sformatf("tbl%0d_rd_b", i), rd_b, tbl[i].e_rd_b);
            chk($sformatf("tbl%0d_busy_a", i), {31'b0, busy_a}, {31'b0, tbl[i].e_ba});
            chk($sformatf("tbl%0d_busy_b", i), {31'b0, busy_b}, {31'b0, tbl[i].e_bb});
            chk($sformatf("tbl%0d_vec", i), busy_vec, tbl[i].e_vec);
            tick();
        end

        // Write GR10 and issue to it in the same edge, then reset between edges.
        we = 1; wa = 10; wd = 32'hA5A5A5A5; iss_en = 1; iss_rd = 10;
        tick();
        idle();
        ra_a = 10; ra_b = 10;
        #2;
        chk("gr10_before_rst", rd_a, 32'hA5A5A5A5);
        chk("vec_before_rst", busy_vec, m_vec());
        chk("vec_bit10", {31'b0, busy_vec[10]}, 32'h1);
        #1;
        rst = 1'b1;
        #0.5;
        chk("async_rst_rd_a", rd_a, 32'h0);
        chk("async_rst_vec", busy_vec, 32'h0);
        we = 1; wa = 10; wd = 32'h77; iss_en = 1; iss_rd = 11;
        #0.5;
        chk("rst_no_bypass", rd_b, 32'h0);
        chk("rst_no_busy", {31'b0, busy_b}, 32'h0);
        @(posedge clk);
        @(negedge clk);
        model_reset();
        rst = 1'b0;
        idle();
        #2;
        chk("rst_write_lost", rd_a, 32'h0);
        chk("rst_issue_lost", busy_vec, 32'h0);

        // Randomized traffic against the model.
        for (int n = 0; n < 400; n++) begin
            we = 1'($urandom); wa = 5'($urandom); wd = $urandom;
            iss_en = 1'($urandom); iss_rd = 5'($urandom_range(0, 7));
            ra_a = 5'($urandom_range(0, 7)); ra_b = 5'($urandom);
            if (n % 5 == 0) ra_b = wa;
            #2;
            chk("rnd_rd_a", rd_a, m_rd(ra_a));
            chk("rnd_rd_b", rd_b, m_rd(ra_b));
            chk("rnd_busy_a", {31'b0, busy_a}, {31'b0, m_busy(ra_a)});
            chk("rnd_busy_b", {31'b0, busy_b}, {31'b0, m_busy(ra_b)});
            chk("rnd_vec", busy_vec, m_vec());
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
